ex_stage: RTL
=============

# ex_stage

Execute stage of the RV32I pipeline: takes a decoded instruction from the ID/EX boundary, resolves register operands through MEM/WB forwarding, drives the ALU, and resolves branches and jumps. Results are captured in the EX/MEM pipeline register, which supports downstream stall and pipeline flush. It also produces a registered one-cycle fetch redirect for taken branches, `jal` and `jalr`.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `id_valid` input 1: the ID/EX slot holds a real instruction.
- `id_pc`, `id_imm` input 32 each: instruction PC and sign-extended immediate.
- `id_rs1_data`, `id_rs2_data` input 32 each: register-file read data.
- `id_rs1`, `id_rs2`, `id_rd` input 5 each: source and destination register indices.
- `id_alu_op` input 4: ALU operation code, using the shared `ALU_*` encodings.
- `id_src_a_pc` input 1: when 1, operand A is the PC; otherwise forwarded rs1.
- `id_src_b_imm` input 1: when 1, operand B is the immediate; otherwise forwarded rs2.
- `id_reg_write`, `id_mem_read`, `id_mem_write` input 1 each: control flags passed through to EX/MEM.
- `id_funct3` input 3: branch condition, or load/store size.
- `id_branch`, `id_jal`, `id_jalr` input 1 each: control-flow type; at most one is set.
- `mem_fwd_we`, `wb_fwd_we` input 1 each: the MEM-stage or WB-stage instruction writes rd.
- `mem_fwd_rd`, `wb_fwd_rd` input 5 each: destination index of that instruction.
- `mem_fwd_data`, `wb_fwd_data` input 32 each: value that instruction will write.
- `stall` input 1: downstream cannot accept; hold the EX/MEM register.
- `flush` input 1: kill the instruction entering EX/MEM.
- `ex_valid` output 1: EX/MEM slot holds a real instruction.
- `ex_result` output 32: ALU result, or PC+4 for `jal`/`jalr`.
- `ex_store_data` output 32: forwarded rs2 value.
- `ex_rd` output 5, `ex_funct3` output 3: passed through.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write` output 1 each: qualified copies of the input flags.
- `redirect_valid` output 1, `redirect_pc` output 32: fetch redirect.

## Operation
- **Forwarding (per source):**
  - Priority is MEM, then WB, then register-file data.
  - A source is forwarded only when the stage's write-enable is 1 and its rd equals the source index.
  - Index 0 is never forwarded; its value stays `id_rsX_data`.
- **Operand muxing:**
  - A is the PC or forwarded rs1.
  - B is the immediate or forwarded rs2.
  - The ALU is combinational. Unknown `alu_op` yields 0.
- **Branch condition:** computed on forwarded rs1/rs2 by dedicated comparators, not through the ALU. Mapping from `funct3`:
  - 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU.
  - 010 and 011 mean not taken.
- **Target:**
  - Branch and `jal`: PC+imm.
  - `jalr`: (forwarded rs1 + imm) with bit 0 cleared.
  - All sums are mod 2^32 and wrap silently.
- **Result select:** `jal`/`jalr` write PC+4; all other instructions write the ALU result.
- **Accept:** a cycle with `!stall`.
  - On accept, EX/MEM loads every field.
  - `ex_valid` = `id_valid & !flush`.
  - `ex_reg_write`, `ex_mem_read`, `ex_mem_write` are ANDed with that same valid.
- **Stall:** EX/MEM holds all fields unchanged.
- **Flush:** has priority over stall. `ex_valid` and the three write/read flags clear to 0. Data fields may be held or loaded.
- **Redirect:** on accept of a valid, non-flushed instruction that is taken (branch true, `jal`, or `jalr`), `redirect_valid` is 1 for the next cycle only, with `redirect_pc` = target. Otherwise `redirect_valid` is 0.
  - Redirect is never raised for a stalled or flushed slot.
  - Redirect is never repeated while the slot is held.
- **Reset:** every output register is 0, including `redirect_pc` and `ex_result`. Reset overrides stall and flush in the same cycle.

## Timing
- EX/MEM outputs: latency 1 cycle from the accepting edge.
- Redirect: asserted in the same cycle the instruction appears in EX/MEM, and deasserted the next cycle regardless of `stall`.
- Forwarding uses the MEM/WB values present in the accept cycle; no internal bypass storage.
- `rst` mid-operation: the next edge clears `ex_valid` and `redirect_valid`; the in-flight instruction is lost.

## Structure
- Shared constants in `defines.v`:
  - `ALU_*` codes (existing).
  - New `BR_BEQ` through `BR_BGEU` funct3 values.
  - New `FWD_REG`/`FWD_MEM`/`FWD_WB` select codes.
- One sub-module: the existing `alu`, instantiated unchanged.
- Forwarding, branch compare and the EX/MEM register stay inline.

## Test plan
- **SUB with MEM forwarding:** `id_rs1`=5, `mem_fwd_we`=1, `mem_fwd_rd`=5, `mem_fwd_data`=0x401e1042, rs2 data 0x7fffffff, op SUB → next cycle `ex_result`=0xc01e1043, `ex_valid`=1.
- **x0 and priority:**
  - rs1=0 with MEM/WB rd=0 and write-enable=1 → uses `id_rs1_data`.
  - MEM and WB both match rs2 → MEM data is used.
- **BLT signed vs BLTU:** rs1=0xffffffff, rs2=1, PC=0x100, imm=0x20:
  - BLT → `redirect_valid` for exactly 1 cycle, `redirect_pc`=0x120.
  - BLTU → no redirect.
- **jalr:** rs1=0x1003, imm=2, PC=0x40 → `redirect_pc`=0x1004, `ex_result`=0x44.
- **Stall then flush:**
  - Stall for 3 cycles → EX/MEM outputs constant, no redirect.
  - Flush together with stall → `ex_valid`=0 and `ex_reg_write`=0 on the next cycle.
- **Reset:** assert `rst` while a taken branch is being accepted → all outputs 0 next cycle, no redirect.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: constants and types shared by the RV32I execute stage.
//   ALU_*  : ALU operation codes driven on id_alu_op
//   BR_*   : branch-condition funct3 values
//   FWD_*  : operand forwarding source selects
//   exmem_t: payload held in the EX/MEM pipeline register
package ex_stage_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned FUNCT3_W = 3;

  // ALU operation codes
  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_SLL   = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SLT   = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU  = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_XOR   = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL   = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA   = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OR    = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_AND   = 4'd9;
  localparam logic [ALU_OP_W-1:0] ALU_PASSB = 4'd10;

  // Branch conditions (funct3); 010 and 011 are never taken
  localparam logic [FUNCT3_W-1:0] BR_BEQ  = 3'b000;
  localparam logic [FUNCT3_W-1:0] BR_BNE  = 3'b001;
  localparam logic [FUNCT3_W-1:0] BR_BLT  = 3'b100;
  localparam logic [FUNCT3_W-1:0] BR_BGE  = 3'b101;
  localparam logic [FUNCT3_W-1:0] BR_BLTU = 3'b110;
  localparam logic [FUNCT3_W-1:0] BR_BGEU = 3'b111;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic                valid;
    logic [DATA_W-1:0]   result;
    logic [DATA_W-1:0]   store_data;
    logic [REG_AW-1:0]   rd;
    logic [FUNCT3_W-1:0] funct3;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
  } exmem_t;

  // MEM wins over WB; x0 always reads the register file
  function automatic fwd_sel_e fwd_select(
    input logic [REG_AW-1:0] rs,
    input logic              mem_we,
    input logic [REG_AW-1:0] mem_rd,
    input logic              wb_we,
    input logic [REG_AW-1:0] wb_rd
  );
    fwd_sel_e sel;
    sel = FWD_REG;
    if (rs != '0) begin
      if (mem_we && (mem_rd == rs)) begin
        sel = FWD_MEM;
      end else if (wb_we && (wb_rd == rs)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// ex_stage_alu: combinational RV32I integer ALU.
//   a_i, b_i   : operands
//   op_i       : ALU_* operation code
//   result_c_o : combinational result; unknown codes give 0
module ex_stage_alu
  import ex_stage_pkg::*;
(
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  input  logic [ALU_OP_W-1:0] op_i,
  output logic [DATA_W-1:0]   result_c_o
);

  logic [4:0] shamt;

  assign shamt = b_i[4:0];

  always_comb begin
    result_c_o = '0;
    case (op_i)
      ALU_ADD:   result_c_o = a_i + b_i;
      ALU_SUB:   result_c_o = a_i - b_i;
      ALU_SLL:   result_c_o = a_i << shamt;
      ALU_SLT:   result_c_o = DATA_W'($signed(a_i) < $signed(b_i));
      ALU_SLTU:  result_c_o = DATA_W'(a_i < b_i);
      ALU_XOR:   result_c_o = a_i ^ b_i;
      ALU_SRL:   result_c_o = a_i >> shamt;
      ALU_SRA:   result_c_o = DATA_W'($signed(a_i) >>> shamt);
      ALU_OR:    result_c_o = a_i | b_i;
      ALU_AND:   result_c_o = a_i & b_i;
      ALU_PASSB: result_c_o = b_i;
      default:   result_c_o = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: RV32I execute stage with MEM/WB forwarding, branch/jump
// resolution, EX/MEM pipeline register and a one-cycle fetch redirect.
//   id_*           : decoded instruction from the ID/EX boundary
//   mem_fwd_*      : MEM-stage writeback (forwarding source, priority 1)
//   wb_fwd_*       : WB-stage writeback  (forwarding source, priority 2)
//   stall, flush   : hold EX/MEM / kill the instruction entering EX/MEM
//   ex_*           : registered EX/MEM contents
//   redirect_*     : registered fetch redirect, high for one cycle
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned XLEN = DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [XLEN-1:0]     id_pc,
  input  logic [XLEN-1:0]     id_imm,
  input  logic [XLEN-1:0]     id_rs1_data,
  input  logic [XLEN-1:0]     id_rs2_data,
  input  logic [REG_AW-1:0]   id_rs1,
  input  logic [REG_AW-1:0]   id_rs2,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic                id_src_a_pc,
  input  logic                id_src_b_imm,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic [FUNCT3_W-1:0] id_funct3,
  input  logic                id_branch,
  input  logic                id_jal,
  input  logic                id_jalr,
  input  logic                mem_fwd_we,
  input  logic [REG_AW-1:0]   mem_fwd_rd,
  input  logic [XLEN-1:0]     mem_fwd_data,
  input  logic                wb_fwd_we,
  input  logic [REG_AW-1:0]   wb_fwd_rd,
  input  logic [XLEN-1:0]     wb_fwd_data,
  input  logic                stall,
  input  logic                flush,
  output logic                ex_valid,
  output logic [XLEN-1:0]     ex_result,
  output logic [XLEN-1:0]     ex_store_data,
  output logic [REG_AW-1:0]   ex_rd,
  output logic [FUNCT3_W-1:0] ex_funct3,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                redirect_valid,
  output logic [XLEN-1:0]     redirect_pc
);

  fwd_sel_e          rs1_sel;
  fwd_sel_e          rs2_sel;
  logic [XLEN-1:0]   rs1_fwd;
  logic [XLEN-1:0]   rs2_fwd;
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;
  logic [XLEN-1:0]   alu_res;
  logic [XLEN-1:0]   pc_plus4;
  logic [XLEN-1:0]   pc_target;
  logic [XLEN-1:0]   jalr_sum;
  logic [XLEN-1:0]   target;
  logic [XLEN-1:0]   result;
  logic              br_cond;
  logic              taken;
  logic              slot_valid;

  exmem_t            ex_q;
  exmem_t            ex_d;
  logic              redir_valid_q;
  logic              redir_valid_d;
  logic [XLEN-1:0]   redir_pc_q;
  logic [XLEN-1:0]   redir_pc_d;

  // Operand forwarding
  assign rs1_sel = fwd_select(id_rs1, mem_fwd_we, mem_fwd_rd, wb_fwd_we, wb_fwd_rd);
  assign rs2_sel = fwd_select(id_rs2, mem_fwd_we, mem_fwd_rd, wb_fwd_we, wb_fwd_rd);

  always_comb begin
    rs1_fwd = id_rs1_data;
    case (rs1_sel)
      FWD_MEM: rs1_fwd = mem_fwd_data;
      FWD_WB:  rs1_fwd = wb_fwd_data;
      default: rs1_fwd = id_rs1_data;
    endcase
  end

  always_comb begin
    rs2_fwd = id_rs2_data;
    case (rs2_sel)
      FWD_MEM: rs2_fwd = mem_fwd_data;
      FWD_WB:  rs2_fwd = wb_fwd_data;
      default: rs2_fwd = id_rs2_data;
    endcase
  end

  // Operand select and ALU
  assign op_a = id_src_a_pc  ? id_pc  : rs1_fwd;
  assign op_b = id_src_b_imm ? id_imm : rs2_fwd;

  ex_stage_alu u_alu (
    .a_i        (op_a),
    .b_i        (op_b),
    .op_i       (id_alu_op),
    .result_c_o (alu_res)
  );

  // Branch comparators, independent of the ALU
  always_comb begin
    br_cond = 1'b0;
    case (id_funct3)
      BR_BEQ:  br_cond = (rs1_fwd == rs2_fwd);
      BR_BNE:  br_cond = (rs1_fwd != rs2_fwd);
      BR_BLT:  br_cond = ($signed(rs1_fwd) <  $signed(rs2_fwd));
      BR_BGE:  br_cond = ($signed(rs1_fwd) >= $signed(rs2_fwd));
      BR_BLTU: br_cond = (rs1_fwd <  rs2_fwd);
      BR_BGEU: br_cond = (rs1_fwd >= rs2_fwd);
      default: br_cond = 1'b0;
    endcase
  end

  assign taken = (id_branch & br_cond) | id_jal | id_jalr;

  // Targets and link value; all sums wrap mod 2^32
  assign pc_plus4  = id_pc + XLEN'(4);
  assign pc_target = id_pc + id_imm;
  assign jalr_sum  = rs1_fwd + id_imm;
  assign target    = id_jalr ? (jalr_sum & ~XLEN'(1)) : pc_target;
  assign result    = (id_jal | id_jalr) ? pc_plus4 : alu_res;

  assign slot_valid = id_valid & ~flush;

  // EX/MEM next state: load on accept, flush kills valid/flags even when stalled
  always_comb begin
    ex_d          = ex_q;
    redir_valid_d = 1'b0;
    redir_pc_d    = redir_pc_q;
    if (!stall) begin
      ex_d.result     = result;
      ex_d.store_data = rs2_fwd;
      ex_d.rd         = id_rd;
      ex_d.funct3     = id_funct3;
      ex_d.valid      = slot_valid;
      ex_d.reg_write  = id_reg_write & slot_valid;
      ex_d.mem_read   = id_mem_read  & slot_valid;
      ex_d.mem_write  = id_mem_write & slot_valid;
      redir_valid_d   = slot_valid & taken;
      redir_pc_d      = target;
    end
    if (flush) begin
      ex_d.valid     = 1'b0;
      ex_d.reg_write = 1'b0;
      ex_d.mem_read  = 1'b0;
      ex_d.mem_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q          <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
    end else begin
      ex_q          <= ex_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

  assign ex_valid       = ex_q.valid;
  assign ex_result      = ex_q.result;
  assign ex_store_data  = ex_q.store_data;
  assign ex_rd          = ex_q.rd;
  assign ex_funct3      = ex_q.funct3;
  assign ex_reg_write   = ex_q.reg_write;
  assign ex_mem_read    = ex_q.mem_read;
  assign ex_mem_write   = ex_q.mem_write;
  assign redirect_valid = redir_valid_q;
  assign redirect_pc    = redir_pc_q;

endmodule
